iot_riscv_dbgctrl: RTL

IOT_RISCV_DBGCTRL -- requirements
Module: iot_riscv_dbgctrl

---
 rtl/iot_riscv_dbgctrl.sv | 119 +++++++++++
 1 files changed

// File: rtl/iot_riscv_dbgctrl.sv
// iot_riscv_dbgctrl: bus-mapped debug controller (pause/step/resume FSM, breakpoint cfg, sticky status).
// Data breakpoints are built only when IOT_RISCV_DBGCTRL_DBP_EN is defined.
module iot_riscv_dbgctrl #(
  parameter int unsigned halt_timeout_p = 255
) (
  input  logic        main_clk_i,
  input  logic        main_rst_i,
  input  logic        bus_req_i,
  input  logic        bus_wr_i,
  input  logic [2:0]  bus_addr_i,
  input  logic [31:0] bus_wdata_i,
  output logic        bus_ack_o,
  output logic [31:0] bus_rdata_o,
  input  logic        debug_halt_i,
  input  logic        debug_halt_data_i,
  input  logic        debug_break_i,
  output logic        debug_pause_o,
  output logic        debug_step_o,
  output logic [31:0] bp0_cfg_o,
  output logic [31:0] bp1_cfg_o,
  output logic [31:0] dbp0_cfg_o,
  output logic [31:0] dbp1_cfg_o
);
  typedef enum logic [1:0] {RUN = 2'd0, PAUSING = 2'd1, HALTED = 2'd2, STEPPING = 2'd3} state_t;
  localparam logic [15:0] TO = 16'(halt_timeout_p);
  state_t      r_state, w_state_nxt;
  logic        r_ack, r_step, w_step_nxt;
  logic [31:0] r_rdata, w_rd;
  logic [15:0] r_cnt, w_cnt_inc, w_cnt_nxt;
  logic [4:1]  r_sticky, w_set, w_clr;
  logic [31:0] r_bp0, r_bp1, w_dbp0, w_dbp1;
  logic        w_halt_data, w_acc, w_wr, w_ctrl_wr, w_pause_cmd, w_step_cmd, w_resume_cmd;
  assign w_acc        = bus_req_i && !r_ack;
  assign w_wr         = w_acc && bus_wr_i;
  assign w_ctrl_wr    = w_wr && bus_addr_i == 3'd0;
  assign w_pause_cmd  = w_ctrl_wr && bus_wdata_i[0];
  assign w_step_cmd   = w_ctrl_wr && bus_wdata_i[1];
  assign w_resume_cmd = w_ctrl_wr && bus_wdata_i[2];
  assign w_clr        = (w_wr && bus_addr_i == 3'd1) ? bus_wdata_i[4:1] : 4'b0;
`ifdef IOT_RISCV_DBGCTRL_DBP_EN
  logic [31:0] r_dbp0, r_dbp1;
  always_ff @(posedge main_clk_i) begin
    if (main_rst_i) begin
      r_dbp0 <= '0;
      r_dbp1 <= '0;
    end else begin
      if (w_wr && bus_addr_i == 3'd4) r_dbp0 <= bus_wdata_i;
      if (w_wr && bus_addr_i == 3'd5) r_dbp1 <= bus_wdata_i;
    end
  end
  assign w_dbp0      = r_dbp0;
  assign w_dbp1      = r_dbp1;
  assign w_halt_data = debug_halt_data_i;
`else
  logic w_unused;
  assign w_unused    = debug_halt_data_i;
  assign w_dbp0      = '0;
  assign w_dbp1      = '0;
  assign w_halt_data = 1'b0;
`endif
  assign w_cnt_inc = (r_cnt == TO) ? r_cnt : r_cnt + 16'd1;
  // Breakpoint halts outrank pause/ebreak in RUN; resume outranks step in HALTED.
  always_comb begin
    w_state_nxt = r_state;
    w_set       = '0;
    case (r_state)
      RUN: begin
        w_set       = {1'b0, debug_break_i, w_halt_data, debug_halt_i};
        w_state_nxt = (debug_halt_i || w_halt_data) ? HALTED :
                      (w_pause_cmd || debug_break_i) ? PAUSING : RUN;
      end
      PAUSING: begin
        w_state_nxt = (debug_halt_i || w_halt_data) ? HALTED : PAUSING;
        w_set[4]    = !(debug_halt_i || w_halt_data) && w_cnt_inc == TO;
      end
      HALTED:   w_state_nxt = w_resume_cmd ? RUN : w_step_cmd ? STEPPING : HALTED;
      STEPPING: w_state_nxt = (!r_step && debug_halt_i) ? HALTED : STEPPING;
    endcase
  end
  assign w_step_nxt = r_state == HALTED && w_state_nxt != HALTED;
  assign w_cnt_nxt  = (r_state == PAUSING && w_state_nxt == PAUSING) ? w_cnt_inc : 16'd0;
  always_comb begin
    w_rd = bus_addr_i == 3'd0 ? {30'b0, r_state} :
           bus_addr_i == 3'd1 ? {27'b0, r_sticky, r_state == HALTED} :
           bus_addr_i == 3'd2 ? r_bp0 :
           bus_addr_i == 3'd3 ? r_bp1 :
           bus_addr_i == 3'd4 ? w_dbp0 :
           bus_addr_i == 3'd5 ? w_dbp1 : 32'b0;
  end
  always_ff @(posedge main_clk_i) begin
    if (main_rst_i) begin
      r_state  <= RUN;
      r_ack    <= 1'b0;
      r_rdata  <= '0;
      r_step   <= 1'b0;
      r_cnt    <= '0;
      r_sticky <= '0;
      r_bp0    <= '0;
      r_bp1    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_ack    <= w_acc;
      r_rdata  <= (w_acc && !bus_wr_i) ? w_rd : 32'b0;
      r_step   <= w_step_nxt;
      r_cnt    <= w_cnt_nxt;
      r_sticky <= (r_sticky & ~w_clr) | w_set;
      if (w_wr && bus_addr_i == 3'd2) r_bp0 <= bus_wdata_i;
      if (w_wr && bus_addr_i == 3'd3) r_bp1 <= bus_wdata_i;
    end
  end
  assign bus_ack_o     = r_ack;
  assign bus_rdata_o   = r_rdata;
  assign debug_pause_o = r_state != RUN;
  assign debug_step_o  = r_step;
  assign bp0_cfg_o     = r_bp0;
  assign bp1_cfg_o     = r_bp1;
  assign dbp0_cfg_o    = w_dbp0;
  assign dbp1_cfg_o    = w_dbp1;
endmodule
